// File: rtl/dram_hart_arbiter.sv
// Round-robin owner of the shared DRAM port: one hart holds the grant for a whole
// transaction sequence, and a burst limit hands the port on when others wait.
module dram_hart_arbiter #(
    parameter int NHARTS    = 2,
    parameter int BURST_MAX = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 w_init_done,
    input  logic [NHARTS-1:0]    w_h_req,
    input  logic [NHARTS-1:0]    w_h_le,
    input  logic [NHARTS-1:0]    w_h_we,
    input  logic [32*NHARTS-1:0] w_h_addr,
    input  logic [32*NHARTS-1:0] w_h_wdata,
    input  logic [3*NHARTS-1:0]  w_h_ctrl,
    output logic [NHARTS-1:0]    w_h_busy,
    output logic [31:0]          w_dram_odata_h,
    output logic [31:0]          w_grant,
    output logic                 w_grant_valid,
    output logic [31:0]          w_dram_addr,
    output logic [31:0]          w_dram_wdata,
    output logic [2:0]           w_dram_ctrl,
    output logic                 w_dram_le,
    output logic                 w_dram_we,
    input  logic                 w_dram_busy,
    input  logic [31:0]          w_dram_odata
);
    // state | meaning
    // IDLE  | no owner; pick next requester after r_last once DRAM is initialised
    // GRANT | r_grant owns the DRAM port until it releases or is rotated out
    localparam int GW = $clog2(NHARTS);
    localparam int CW = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        r_state;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_last;
    logic [CW-1:0] r_cnt;
    logic          r_inflight;
    logic          r_issue_d;

    logic [GW-1:0] nxt;
    logic          found;
    int            idx;
    logic          g_le, g_we, g_req, other_req;
    logic          in_grant, issue, complete, release_g;

    always_comb begin
        nxt   = r_last;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NHARTS; k++) begin
            idx = int'(r_last) + k;
            if (idx >= NHARTS) idx = idx - NHARTS;
            if (!found && w_h_req[idx[GW-1:0]]) begin
                found = 1'b1;
                nxt   = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        g_le         = 1'b0;
        g_we         = 1'b0;
        g_req        = 1'b0;
        other_req    = 1'b0;
        w_dram_addr  = w_h_addr[31:0];
        w_dram_wdata = w_h_wdata[31:0];
        w_dram_ctrl  = w_h_ctrl[2:0];
        in_grant     = (r_state == GRANT);
        for (int i = 0; i < NHARTS; i++) begin
            if (r_grant == GW'(i)) begin
                g_le         = w_h_le[i];
                g_we         = w_h_we[i];
                g_req        = w_h_req[i];
                w_dram_addr  = w_h_addr[32*i +: 32];
                w_dram_wdata = w_h_wdata[32*i +: 32];
                w_dram_ctrl  = w_h_ctrl[3*i +: 3];
            end else if (w_h_req[i]) begin
                other_req = 1'b1;
            end
            w_h_busy[i] = (in_grant && r_grant == GW'(i)) ? w_dram_busy : 1'b1;
        end
        issue     = in_grant && (g_le || g_we);
        // r_issue_d masks a busy that only rises the cycle after the issue
        complete  = in_grant && r_inflight && !w_dram_busy && !r_issue_d && !issue;
        release_g = in_grant && !r_inflight && !issue &&
                    (!g_req || (r_cnt == CW'(BURST_MAX) && other_req));
    end

    assign w_dram_le      = in_grant && g_le;
    assign w_dram_we      = in_grant && g_we;
    assign w_grant        = 32'(r_grant);
    assign w_grant_valid  = in_grant;
    assign w_dram_odata_h = w_dram_odata;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_last     <= GW'(NHARTS - 1);
            r_cnt      <= '0;
            r_inflight <= 1'b0;
            r_issue_d  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_issue_d <= 1'b0;
                    if (w_init_done && found) begin
                        r_grant <= nxt;
                        r_cnt   <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    r_issue_d <= issue;
                    if (issue) begin
                        r_inflight <= 1'b1;
                    end else if (complete) begin
                        r_inflight <= 1'b0;
                        if (r_cnt != CW'(BURST_MAX)) r_cnt <= r_cnt + CW'(1);
                    end
                    if (release_g) begin
                        r_last  <= r_grant;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_hart_arbiter.sv
// Scoreboarded bench for dram_hart_arbiter: expected grants and DRAM accesses are queued
// by the stimulus and consumed by an independent monitor.
module tb_dram_hart_arbiter;
    localparam int NH = 2;

    logic            CLK = 1'b0;
    logic            RST;
    logic            w_init_done;
    logic [NH-1:0]   w_h_req, w_h_le, w_h_we, w_h_busy;
    logic [32*NH-1:0] w_h_addr, w_h_wdata;
    logic [3*NH-1:0] w_h_ctrl;
    logic [31:0]     w_dram_odata_h, w_grant, w_dram_addr, w_dram_wdata, w_dram_odata;
    logic            w_grant_valid, w_dram_le, w_dram_we, w_dram_busy;
    logic [2:0]      w_dram_ctrl;

    dram_hart_arbiter #(.NHARTS(NH), .BURST_MAX(16)) dut (
        .CLK(CLK), .RST(RST), .w_init_done(w_init_done),
        .w_h_req(w_h_req), .w_h_le(w_h_le), .w_h_we(w_h_we),
        .w_h_addr(w_h_addr), .w_h_wdata(w_h_wdata), .w_h_ctrl(w_h_ctrl),
        .w_h_busy(w_h_busy), .w_dram_odata_h(w_dram_odata_h),
        .w_grant(w_grant), .w_grant_valid(w_grant_valid),
        .w_dram_addr(w_dram_addr), .w_dram_wdata(w_dram_wdata), .w_dram_ctrl(w_dram_ctrl),
        .w_dram_le(w_dram_le), .w_dram_we(w_dram_we),
        .w_dram_busy(w_dram_busy), .w_dram_odata(w_dram_odata)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] g;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
        logic        le;
        logic        we;
    } txn_t;

    txn_t txn_q[$];
    int   grant_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   txn_seen = 0;
    int   gaps = 0;
    int   idle_len = 0;
    bit   chk_gap = 0;
    bit   prev_v = 0;
    int   lat = 1;
    int   bcnt = 0;
    bit   iss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_txn(input int g, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] c, input logic le, input logic we);
        txn_t t;
        t.g = 32'(g); t.addr = a; t.wdata = d; t.ctrl = c; t.le = le; t.we = we;
        txn_q.push_back(t);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // DRAM controller model: busy for 'lat' cycles starting the cycle after an access
    initial begin
        w_dram_busy = 1'b0;
        forever begin
            @(negedge CLK);
            iss = w_dram_le | w_dram_we;
            @(posedge CLK);
            #1;
            if (RST) bcnt = 0;
            else if (iss) bcnt = lat;
            else if (bcnt > 0) bcnt--;
            w_dram_busy = (bcnt > 0);
        end
    end

    // Monitor: grant rises and DRAM accesses are checked against the queues
    initial begin
        txn_t t;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_v = 0;
                idle_len = 0;
            end else begin
                if (w_grant_valid && !prev_v) begin
                    if (grant_q.size() == 0) begin
                        chk("unexpected_grant", w_grant, 32'hFFFF_FFFF);
                    end else begin
                        chk("grant_order", w_grant, 32'(grant_q.pop_front()));
                    end
                    if (chk_gap) begin
                        chk("idle_gap", 32'(idle_len), 32'd1);
                        gaps++;
                    end
                    idle_len = 0;
                end
                if (!w_grant_valid) idle_len++;
                prev_v = w_grant_valid;
                if (w_dram_le || w_dram_we) begin
                    txn_seen++;
                    if (txn_q.size() == 0) begin
                        chk("unexpected_access", w_dram_addr, 32'hFFFF_FFFF);
                    end else begin
                        t = txn_q.pop_front();
                        chk("txn_addr", w_dram_addr, t.addr);
                        chk("txn_wdata", w_dram_wdata, t.wdata);
                        chk("txn_misc", {w_grant[3:0], w_dram_ctrl, w_dram_le, w_dram_we},
                            {t.g[3:0], t.ctrl, t.le, t.we});
                    end
                end
            end
        end
    end

    initial begin
        int cool[2];
        int hidx[2];
        logic [31:0] base_a[2];
        int base_seen;
        bit done;

        RST = 1'b1; w_init_done = 1'b0; w_h_req = '0; w_h_le = '0; w_h_we = '0;
        w_h_addr = '0; w_h_wdata = '0; w_h_ctrl = '0; w_dram_odata = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_valid", 32'(w_grant_valid), 32'd0);
        chk("rst_grant", w_grant, 32'd0);
        chk("rst_busy", 32'(w_h_busy), 32'd3);
        chk("rst_le_we", {30'd0, w_dram_le, w_dram_we}, 32'd0);

        // no grant while DRAM uninitialised
        cyc(); RST = 1'b0; w_h_req = 2'b11;
        repeat (3) begin
            @(negedge CLK);
            chk("no_grant_before_init", {29'd0, w_grant_valid, w_h_busy}, 32'b011);
            cyc();
        end
        w_init_done = 1'b1; grant_q.push_back(0);
        @(negedge CLK); chk("init_idle", 32'(w_grant_valid), 32'd0);
        cyc(); @(negedge CLK); chk("first_grant", {w_grant[30:0], w_grant_valid}, 32'd1);

        // hart 0 load, busy 3 cycles
        cyc(); lat = 3; w_dram_odata = 32'hDEADBEEF;
        w_h_addr[31:0] = 32'h8000_1000; w_h_ctrl[2:0] = 3'b010; w_h_le[0] = 1'b1;
        push_txn(0, 32'h8000_1000, 32'h0, 3'b010, 1'b1, 1'b0);
        @(negedge CLK); chk("load_addr", w_dram_addr, 32'h8000_1000);
        cyc(); w_h_le[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            @(negedge CLK);
            chk("busy_follow", 32'(w_h_busy), (k < 3) ? 32'd3 : 32'd2);
        end
        chk("odata_bcast", w_dram_odata_h, 32'hDEADBEEF);

        // non-granted hart's le is ignored
        cyc(); w_h_le[1] = 1'b1;
        @(negedge CLK);
        chk("foreign_le", {29'd0, w_dram_le, w_h_busy[1], w_grant_valid}, 32'b011);
        cyc(); w_h_le[1] = 1'b0; w_h_req[0] = 1'b0; grant_q.push_back(1);
        @(negedge CLK); chk("release_cycle", 32'(w_grant_valid), 32'd1);
        cyc(); @(negedge CLK); chk("dead_cycle", 32'(w_grant_valid), 32'd0);
        cyc(); @(negedge CLK); chk("grant_h1", {w_grant[30:0], w_grant_valid}, 32'd3);

        // hart 0 drops req together with a write
        cyc(); w_h_req = 2'b01; grant_q.push_back(0);
        @(negedge CLK); chk("h1_release", 32'(w_grant_valid), 32'd1);
        cyc(); @(negedge CLK); chk("h1_dead", 32'(w_grant_valid), 32'd0);
        cyc(); @(negedge CLK); chk("grant_h0", {w_grant[30:0], w_grant_valid}, 32'd1);
        cyc(); lat = 2; w_h_req = 2'b00; w_h_we[0] = 1'b1;
        w_h_addr[31:0] = 32'h8000_2000; w_h_wdata[31:0] = 32'h1234_5678; w_h_ctrl[2:0] = 3'b001;
        push_txn(0, 32'h8000_2000, 32'h1234_5678, 3'b001, 1'b0, 1'b1);
        @(negedge CLK); chk("we_issue", 32'(w_dram_we), 32'd1);
        cyc(); w_h_we[0] = 1'b0;
        @(negedge CLK); chk("we_once", {30'd0, w_dram_we, w_grant_valid}, 32'b01);
        for (int k = 0; k < 4; k++) begin
            cyc(); @(negedge CLK);
            chk("hold_until_done", 32'(w_grant_valid), (k < 3) ? 32'd1 : 32'd0);
        end

        // reset in the middle of a hart 1 transaction
        cyc(); w_h_req = 2'b10; grant_q.push_back(1);
        cyc(); @(negedge CLK); chk("grant_h1_again", {w_grant[30:0], w_grant_valid}, 32'd3);
        cyc(); lat = 5; w_h_le[1] = 1'b1; w_h_addr[63:32] = 32'h8000_3000;
        push_txn(1, 32'h8000_3000, 32'h0, 3'b000, 1'b1, 1'b0);
        cyc(); w_h_le[1] = 1'b0;
        #2 RST = 1'b1;
        #1;
        chk("async_rst", {w_grant[28:0], w_grant_valid, w_h_busy}, 32'b011);
        w_h_req = 2'b11; grant_q.push_back(0);
        w_h_ctrl = '0; w_h_wdata = '0;
        cyc(); cyc(); RST = 1'b0;
        @(negedge CLK); chk("post_rst_idle", 32'(w_grant_valid), 32'd0);
        cyc(); @(negedge CLK); chk("post_rst_h0_first", {w_grant[30:0], w_grant_valid}, 32'd1);

        // burst rotation: both harts request continuously
        base_a[0] = 32'h4000_0000; base_a[1] = 32'h5000_0000;
        cool[0] = 0; cool[1] = 0; hidx[0] = 0; hidx[1] = 0;
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 16; k++)
                push_txn(p % 2, ((p % 2) ? base_a[1] : base_a[0]) + 32'((p == 2 ? 16 + k : k) * 4),
                         32'h0, 3'b000, 1'b1, 1'b0);
        grant_q.push_back(1); grant_q.push_back(0);
        chk_gap = 1; lat = 1;
        base_seen = txn_seen;
        done = 0;
        for (int c = 0; c < 1000 && !done; c++) begin
            cyc();
            if (txn_seen - base_seen >= 48) begin
                w_h_le = '0; w_h_req = '0; done = 1;
            end else begin
                for (int h = 0; h < 2; h++) begin
                    if (cool[h] > 0) begin
                        cool[h]--; w_h_le[h] = 1'b0;
                    end else if (w_grant_valid && w_grant == 32'(h)) begin
                        w_h_le[h] = 1'b1;
                        w_h_addr[32*h +: 32] = base_a[h] + 32'(hidx[h] * 4);
                        hidx[h]++; cool[h] = 3;
                    end else begin
                        w_h_le[h] = 1'b0;
                    end
                end
            end
        end
        if (!done) begin
            chk("burst_timeout", 32'(txn_seen - base_seen), 32'd48);
            w_h_le = '0; w_h_req = '0;
        end
        repeat (10) cyc();
        @(negedge CLK);
        chk("final_idle", 32'(w_grant_valid), 32'd0);
        chk("txn_q_empty", 32'(txn_q.size()), 32'd0);
        chk("grant_q_empty", 32'(grant_q.size()), 32'd0);
        chk("gap_checks", 32'(gaps), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
